// File: rtl/syscall_sequencer_pkg.sv
// Shared types and constants for the syscall sequencer: FSM states, syscall
// codes, error codes, string-window defaults and the byte-lane selector.
package syscall_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INT      = 3'd1,
    ST_STR_RD   = 3'd2,
    ST_STR_EMIT = 3'd3,
    ST_DONE     = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CODE = 2'd1;
  localparam logic [1:0] ERR_BAD_ADDR = 2'd2;
  localparam logic [1:0] ERR_BREAK    = 2'd3;

  localparam logic [31:0] TEXT_BASE_DEF  = 32'h0040_0000;
  localparam logic [31:0] TEXT_LIMIT_DEF = 32'h0040_0400;

  // Little-endian byte lane: lane 0 is word[7:0].
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/syscall_sequencer_counters.sv
// Free-running cycle counter and retired-instruction counter, both frozen
// while the sequencer is halted.
module sysc_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        retire_i,
  output logic [31:0] cycle_count_o,
  output logic [31:0] insn_count_o
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] insn_q, insn_d;

  // Next-count logic; both counters wrap naturally at 2^32.
  always_comb begin
    cycle_d = cycle_q;
    insn_d  = insn_q;
    if (en_i) begin
      cycle_d = cycle_q + 32'd1;
      if (retire_i) begin
        insn_d = insn_q + 32'd1;
      end else begin
        insn_d = insn_q;
      end
    end else begin
      cycle_d = cycle_q;
      insn_d  = insn_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 32'd0;
      insn_q  <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
      insn_q  <= insn_d;
    end
  end

  assign cycle_count_o = cycle_q;
  assign insn_count_o  = insn_q;

endmodule

// File: rtl/syscall_sequencer.sv
// Syscall sequencer: stalls the pipeline on a syscall, streams integer or
// NUL-terminated string output over a valid/ready channel, and handles exit.
module syscall_sequencer
  import syscall_sequencer_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEF,
  parameter logic [31:0] TEXT_LIMIT = TEXT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_i,
  input  logic        brk_i,
  input  logic [31:0] regv_i,
  input  logic [31:0] rega_i,
  input  logic        retire_i,
  input  logic [29:0] fetch_addr_i,
  output logic [29:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic        stall_o,
  output logic        out_valid_o,
  output logic        out_is_int_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        halt_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] insn_count_o
);

  localparam logic [29:0] LIMIT_WORD = TEXT_LIMIT[31:2];

  state_e      state_q;
  logic [29:0] ptr_q;
  logic [1:0]  bidx_q;
  logic [31:0] wbuf_q;
  logic        out_valid_q;
  logic        out_is_int_q;
  logic [31:0] out_data_q;
  logic        halt_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        in_window_s;
  logic [7:0]  rd_byte_s;
  logic [1:0]  bidx_inc_s;
  logic [7:0]  nxt_byte_s;
  logic        last_word_s;

  assign in_window_s = (rega_i >= TEXT_BASE) && (rega_i < TEXT_LIMIT);
  assign rd_byte_s   = byte_sel(imem_data_i, bidx_q);
  assign bidx_inc_s  = bidx_q + 2'd1;
  assign nxt_byte_s  = byte_sel(wbuf_q, bidx_inc_s);
  assign last_word_s = (ptr_q + 30'd1) == LIMIT_WORD;

  // Instruction-memory port is shared: fetch owns it only while idle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      imem_addr_o = fetch_addr_i;
      inst_o      = imem_data_i;
      stall_o     = sys_i;
    end else begin
      imem_addr_o = ptr_q;
      inst_o      = 32'h0000_0000;
      stall_o     = 1'b1;
    end
  end

  // Sequencer FSM; the next output beat is computed on entry to STR_EMIT so
  // that out_valid/out_data come straight from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 30'd0;
      bidx_q       <= 2'd0;
      wbuf_q       <= 32'd0;
      out_valid_q  <= 1'b0;
      out_is_int_q <= 1'b0;
      out_data_q   <= 32'd0;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sys_i) begin
            if (brk_i) begin
              state_q    <= ST_HALT;
              halt_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= ERR_BREAK;
            end else if (regv_i == SYS_PRINT_INT) begin
              state_q      <= ST_INT;
              out_valid_q  <= 1'b1;
              out_is_int_q <= 1'b1;
              out_data_q   <= rega_i;
            end else if (regv_i == SYS_PRINT_STR) begin
              if (in_window_s) begin
                state_q <= ST_STR_RD;
                ptr_q   <= rega_i[31:2];
                bidx_q  <= rega_i[1:0];
              end else begin
                state_q    <= ST_DONE;
                err_q      <= 1'b1;
                err_code_q <= ERR_BAD_ADDR;
              end
            end else if (regv_i == SYS_EXIT) begin
              state_q <= ST_HALT;
              halt_q  <= 1'b1;
            end else begin
              state_q    <= ST_DONE;
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_CODE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_INT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_INT;
          end
        end
        ST_STR_RD: begin
          wbuf_q       <= imem_data_i;
          out_valid_q  <= (rd_byte_s != 8'h00);
          out_is_int_q <= 1'b0;
          out_data_q   <= {24'h00_0000, rd_byte_s};
          state_q      <= ST_STR_EMIT;
        end
        ST_STR_EMIT: begin
          if (!out_valid_q) begin
            // Terminator reached: no beat was presented for it.
            state_q <= ST_DONE;
          end else if (out_ready_i) begin
            if (bidx_q != 2'd3) begin
              bidx_q      <= bidx_inc_s;
              out_valid_q <= (nxt_byte_s != 8'h00);
              out_data_q  <= {24'h00_0000, nxt_byte_s};
            end else begin
              bidx_q      <= 2'd0;
              out_valid_q <= 1'b0;
              if (last_word_s) begin
                state_q    <= ST_DONE;
                err_q      <= 1'b1;
                err_code_q <= ERR_BAD_ADDR;
              end else begin
                ptr_q   <= ptr_q + 30'd1;
                state_q <= ST_STR_RD;
              end
            end
          end else begin
            state_q <= ST_STR_EMIT;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_is_int_o = out_is_int_q;
  assign out_data_o   = out_data_q;
  assign halt_o       = halt_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

  sysc_counters u_counters (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (~halt_q),
    .retire_i      (retire_i),
    .cycle_count_o (cycle_count_o),
    .insn_count_o  (insn_count_o)
  );

endmodule

// File: tb/tb_syscall_sequencer.sv
// Self-checking bench for syscall_sequencer: directed vector table, hand-written
// halt/reset sequences and randomized syscalls against a byte-walking model.
module tb_syscall_sequencer;

  localparam logic [31:0] TB_BASE  = 32'h0040_0000;
  localparam logic [31:0] TB_LIMIT = 32'h0040_0400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sys_i = 1'b0, brk_i = 1'b0, retire_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] regv_i = 32'd0, rega_i = 32'd0;
  logic [29:0] fetch_addr_i = 30'd0;
  logic [29:0] imem_addr_o;
  logic [31:0] imem_data_i, inst_o, out_data_o, cycle_count_o, insn_count_o;
  logic        stall_o, out_valid_o, out_is_int_o, halt_o, err_o;
  logic [1:0]  err_code_o;

  logic [31:0] mem [0:255];

  syscall_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sys_i(sys_i), .brk_i(brk_i), .regv_i(regv_i),
    .rega_i(rega_i), .retire_i(retire_i), .fetch_addr_i(fetch_addr_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i), .inst_o(inst_o),
    .stall_o(stall_o), .out_valid_o(out_valid_o), .out_is_int_o(out_is_int_o),
    .out_data_o(out_data_o), .out_ready_i(out_ready_i), .halt_o(halt_o),
    .err_o(err_o), .err_code_o(err_code_o), .cycle_count_o(cycle_count_o),
    .insn_count_o(insn_count_o)
  );

  always #5 clk = ~clk;

  assign imem_data_i = (imem_addr_o[29:8] == 22'h00_1000) ? mem[imem_addr_o[7:0]] : 32'hDEAD_BEEF;

  // Counter reference: counts edges while not halted.
  int unsigned m_cyc, m_insn;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_insn <= 0;
    end else if (!halt_o) begin
      m_cyc <= m_cyc + 1;
      if (retire_i) m_insn <= m_insn + 1;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] got_data[$];
  logic        got_int[$];
  logic [31:0] exp_data[$];
  int          err_pulses, stall_cycles;
  logic [1:0]  err_seen_code;

  // mode: 0 ready always, 1 toggling, 2 random. rmode: 0 none, 1 random, 2 dispatch only.
  task automatic run_sys(input logic brk, input logic [31:0] regv, input logic [31:0] rega,
                         input int mode, input int rmode);
    logic        prev_hold, rdy, done;
    logic [31:0] prev_data;
    got_data.delete(); got_int.delete();
    err_pulses = 0; err_seen_code = 2'd0;
    @(negedge clk);
    sys_i = 1'b1; brk_i = brk; regv_i = regv; rega_i = rega;
    retire_i = (rmode == 2) ? 1'b1 : ((rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    #1 check("dispatch_stall", 32'(stall_o), 32'd1);
    stall_cycles = 1;
    prev_hold = 1'b0; prev_data = 32'd0; rdy = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      sys_i = 1'b0; brk_i = 1'b0;
      retire_i = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready_i = rdy;
      #1;
      if (err_o) begin
        err_pulses++;
        err_seen_code = err_code_o;
      end
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid_o), 32'd1);
        check("hold_data", out_data_o, prev_data);
      end
      if (halt_o || !stall_o) begin
        done = 1'b1;
      end else begin
        stall_cycles++;
        if (inst_o !== 32'd0) check("inst_zero_busy", inst_o, 32'd0);
        if (out_valid_o && rdy) begin
          got_data.push_back(out_data_o);
          got_int.push_back(out_is_int_o);
        end
        prev_hold = out_valid_o && !rdy;
        prev_data = out_data_o;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    out_ready_i = 1'b0;
    retire_i = 1'b0;
  endtask

  task automatic cmp_beats(input logic exp_is_int);
    check("beat_count", 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check("beat_data", got_data[i], exp_data[i]);
      check("beat_is_int", 32'(got_int[i]), 32'(exp_is_int));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sys_i = 1'b0; brk_i = 1'b0; retire_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: walk string bytes from rega until NUL or the window end.
  task automatic model_sys(input logic [31:0] regv, input logic [31:0] rega,
                           output logic [1:0] e, output logic ex_int, output logic ex_halt);
    logic [31:0] a, w;
    logic [7:0]  b, idx;
    exp_data.delete(); e = 2'd0; ex_int = 1'b0; ex_halt = 1'b0;
    if (regv == 32'd1) begin
      exp_data.push_back(rega);
      ex_int = 1'b1;
    end else if (regv == 32'd4) begin
      if (rega < TB_BASE || rega >= TB_LIMIT) begin
        e = 2'd2;
      end else begin
        a = rega;
        for (int k = 0; k < 2000; k++) begin
          if (a >= TB_LIMIT) begin e = 2'd2; break; end
          idx = 8'((a - TB_BASE) >> 2);
          w = mem[idx];
          b = 8'(w >> {a[1:0], 3'b000});
          if (b == 8'd0) break;
          exp_data.push_back({24'd0, b});
          a = a + 32'd1;
        end
      end
    end else if (regv == 32'd10) begin
      ex_halt = 1'b1;
    end else begin
      e = 2'd1;
    end
  endtask

  typedef struct {
    logic        brk;
    logic [31:0] regv;
    logic [31:0] rega;
    int          mode;
    int          nbeats;
    logic [63:0] bytes;
    logic        exp_int;
    logic [1:0]  exp_err;
    logic        exp_halt;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [29:0] fa;
    logic [31:0] exp_inst;
  } fvec_t;

  vec_t  vt[12];
  fvec_t ft[4];

  initial begin
    logic [1:0]  me;
    logic        mi, mh;
    logic [31:0] rv, ra;
    logic [31:0] codes[6];

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0]   = 32'h6C6C_6548;
    mem[1]   = 32'h0000_0A6F;
    mem[255] = 32'h4142_4344;

    vt[0]  = '{1'b0, 32'd1,  32'd42,         0, 1, 64'd0,                  1'b1, 2'd0, 1'b0, 3};
    vt[1]  = '{1'b0, 32'd4,  32'h0040_0000,  0, 6, 64'h0000_0A6F_6C6C_6548, 1'b0, 2'd0, 1'b0, 11};
    vt[2]  = '{1'b0, 32'd4,  32'h0040_0002,  1, 4, 64'h0000_0000_0A6F_6C6C, 1'b0, 2'd0, 1'b0, -1};
    vt[3]  = '{1'b0, 32'd4,  32'h0040_0400,  0, 0, 64'd0,                  1'b0, 2'd2, 1'b0, 2};
    vt[4]  = '{1'b0, 32'd7,  32'd0,          0, 0, 64'd0,                  1'b0, 2'd1, 1'b0, 2};
    vt[5]  = '{1'b0, 32'd4,  32'h003F_FFFF,  0, 0, 64'd0,                  1'b0, 2'd2, 1'b0, 2};
    vt[6]  = '{1'b0, 32'd4,  32'h0040_03FC,  2, 4, 64'h0000_0000_4142_4344, 1'b0, 2'd2, 1'b0, -1};
    vt[7]  = '{1'b0, 32'd4,  32'h0040_03FF,  0, 1, 64'h0000_0000_0000_0041, 1'b0, 2'd2, 1'b0, -1};
    vt[8]  = '{1'b0, 32'd0,  32'd0,          0, 0, 64'd0,                  1'b0, 2'd1, 1'b0, 2};
    vt[9]  = '{1'b0, 32'd1,  32'hFFFF_FFFF,  1, 1, 64'd0,                  1'b1, 2'd0, 1'b0, -1};
    vt[10] = '{1'b1, 32'd1,  32'd5,          0, 0, 64'd0,                  1'b0, 2'd3, 1'b1, 1};
    vt[11] = '{1'b0, 32'd10, 32'd0,          0, 0, 64'd0,                  1'b0, 2'd0, 1'b1, 1};

    ft[0] = '{30'h0010_0000, 32'h6C6C_6548};
    ft[1] = '{30'h0010_0001, 32'h0000_0A6F};
    ft[2] = '{30'h0000_0000, 32'hDEAD_BEEF};
    ft[3] = '{30'h0010_00FF, 32'h4142_4344};

    // Reset state, sampled while reset is still asserted.
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data", out_data_o, 32'd0);
    check("rst_halt", 32'(halt_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_err_code", 32'(err_code_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_cycle", cycle_count_o, 32'd0);
    check("rst_insn", insn_count_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle pass-through of the fetch path.
    foreach (ft[i]) begin
      @(negedge clk);
      fetch_addr_i = ft[i].fa;
      #1;
      check("idle_imem_addr", 32'(imem_addr_o), 32'(ft[i].fa));
      check("idle_inst", inst_o, ft[i].exp_inst);
      check("idle_stall", 32'(stall_o), 32'd0);
    end

    // Directed vector table.
    foreach (vt[i]) begin
      run_sys(vt[i].brk, vt[i].regv, vt[i].rega, vt[i].mode, 1);
      exp_data.delete();
      if (vt[i].exp_int) exp_data.push_back(vt[i].rega);
      else for (int k = 0; k < vt[i].nbeats; k++) exp_data.push_back({24'd0, vt[i].bytes[8*k +: 8]});
      cmp_beats(vt[i].exp_int);
      check("vec_err_pulses", 32'(err_pulses), (vt[i].exp_err != 2'd0) ? 32'd1 : 32'd0);
      if (vt[i].exp_err != 2'd0) begin
        check("vec_err_code", 32'(err_seen_code), 32'(vt[i].exp_err));
        check("vec_err_code_hold", 32'(err_code_o), 32'(vt[i].exp_err));
      end
      check("vec_halt", 32'(halt_o), 32'(vt[i].exp_halt));
      if (vt[i].exp_stall > 0) check("vec_stall_cycles", 32'(stall_cycles), 32'(vt[i].exp_stall));
      check("vec_cycle_count", cycle_count_o, m_cyc);
      check("vec_insn_count", insn_count_o, m_insn);
      if (vt[i].exp_halt) do_reset();
    end

    // Exit after 49 idle retires plus one retire in the dispatch cycle.
    do_reset();
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      retire_i = 1'b1;
    end
    run_sys(1'b0, 32'd10, 32'd0, 0, 2);
    check("exit_halt", 32'(halt_o), 32'd1);
    check("exit_insn", insn_count_o, 32'd50);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sys_i = 1'b1; regv_i = 32'd1; retire_i = 1'b1; out_ready_i = 1'b1;
      #1;
      check("halt_stall", 32'(stall_o), 32'd1);
      check("halt_no_out", 32'(out_valid_o), 32'd0);
      check("halt_sticky", 32'(halt_o), 32'd1);
      check("halt_insn_frozen", insn_count_o, 32'd50);
      check("halt_cycle_frozen", cycle_count_o, m_cyc);
    end
    do_reset();

    // Asynchronous reset while a string beat is waiting.
    @(negedge clk);
    sys_i = 1'b1; regv_i = 32'd4; rega_i = 32'h0040_03FC; out_ready_i = 1'b0; retire_i = 1'b1;
    @(negedge clk);
    sys_i = 1'b0;
    for (int i = 0; i < 10 && !out_valid_o; i++) @(negedge clk);
    check("midstr_valid_before", 32'(out_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midstr_rst_valid", 32'(out_valid_o), 32'd0);
    check("midstr_rst_data", out_data_o, 32'd0);
    check("midstr_rst_stall", 32'(stall_o), 32'd0);
    check("midstr_rst_cycle", cycle_count_o, 32'd0);
    check("midstr_rst_insn", insn_count_o, 32'd0);
    @(negedge clk);
    retire_i = 1'b0;
    rst_n = 1'b1;

    // Randomized syscalls over random string memory.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      for (int b = 0; b < 4; b++) begin
        logic [7:0] by;
        by = ($urandom_range(0, 9) == 0 && i < 254) ? 8'd0 : 8'($urandom_range(1, 255));
        w[8*b +: 8] = by;
      end
      mem[i] = w;
    end
    codes[0] = 32'd1; codes[1] = 32'd4; codes[2] = 32'd4;
    codes[3] = 32'd4; codes[4] = 32'd7; codes[5] = 32'd4;
    for (int t = 0; t < 40; t++) begin
      rv = codes[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0:       ra = TB_LIMIT - 32'($urandom_range(1, 24));
        1:       ra = ($urandom_range(0, 1) == 1) ? TB_LIMIT + 32'($urandom_range(0, 8))
                                                  : TB_BASE - 32'($urandom_range(1, 8));
        default: ra = TB_BASE + 32'($urandom_range(0, 1023));
      endcase
      if (rv == 32'd1) ra = $urandom;
      model_sys(rv, ra, me, mi, mh);
      run_sys(1'b0, rv, ra, 2, 1);
      cmp_beats(mi);
      check("rnd_err_pulses", 32'(err_pulses), (me != 2'd0) ? 32'd1 : 32'd0);
      if (me != 2'd0) check("rnd_err_code", 32'(err_seen_code), 32'(me));
      check("rnd_halt", 32'(halt_o), 32'(mh));
      check("rnd_cycle_count", cycle_count_o, m_cyc);
      check("rnd_insn_count", insn_count_o, m_insn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
